// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: sequencer that runs one unit_SRAM_dp macro as a synchronous
// 32-bit FIFO. Port A of the macro is the dedicated write port, port B is the
// dedicated read port. Read data is re-timed into a pop_valid-qualified stream.
// Optional build macro: SRAM_FIFO_ALMOST_EN adds registered almost_full /
// almost_empty outputs driven from AF_THRESH / AE_THRESH.
module sram_fifo_ctrl #(
   parameter int unsigned DEPTH_LOG2 = 9,
   parameter int unsigned ADDR_SHIFT = 5,
   parameter logic [2:0]  CONF       = 3'b000,
   parameter bit          OUT_REG    = 1'b0,
   parameter int unsigned RD_LAT     = 2,
   parameter int unsigned AF_THRESH  = 480,
   parameter int unsigned AE_THRESH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  push,
   input  logic [31:0]           push_data,
   input  logic                  pop,
   output logic [31:0]           pop_data,
   output logic                  pop_valid,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  sram_csb,
   output logic                  sram_web,
   output logic                  sram_reb,
   output logic [13:0]           sram_addr_w,
   output logic [13:0]           sram_addr_r,
   output logic [2:0]            sram_conf,
   output logic                  sram_out_reg,
   output logic [31:0]           sram_d_in,
   input  logic [31:0]           sram_d_out
`ifdef SRAM_FIFO_ALMOST_EN
   ,
   output logic                  almost_full,
   output logic                  almost_empty
`endif
);

   localparam int unsigned          AW      = 14;
   localparam int unsigned          DEPTH   = 1 << DEPTH_LOG2;
   // Read data arrives RD_LAT cycles after accept, one more if the macro's
   // output register is enabled.
   localparam int unsigned          LAT     = RD_LAT + (OUT_REG ? 1 : 0);
   localparam logic [DEPTH_LOG2:0]  CNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  csb_q, csb_d;
   logic                  web_q, web_d;
   logic                  reb_q, reb_d;
   logic [AW-1:0]         addr_w_q, addr_w_d;
   logic [AW-1:0]         addr_r_q, addr_r_d;
   logic [31:0]           d_in_q, d_in_d;
   logic [LAT-1:0]        vld_q, vld_d;

   logic                  full_w;
   logic                  empty_w;
   logic                  push_acc;
   logic                  pop_acc;

   // Acceptance: status comes from the registered count, so a push into an
   // empty FIFO is never matched by a same-cycle pop, and a pop from a full
   // FIFO frees no room for a same-cycle push.
   always_comb begin
      full_w   = (count_q == CNT_MAX);
      empty_w  = (count_q == '0);
      push_acc = push & ~full_w;
      pop_acc  = pop & ~empty_w;
   end

   // Next state for pointers, occupancy, sticky flags and the SRAM command
   // registers; clr forces everything back to the idle/reset picture.
   always_comb begin
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      csb_d    = 1'b1;
      web_d    = 1'b1;
      reb_d    = 1'b1;
      addr_w_d = addr_w_q;
      addr_r_d = addr_r_q;
      d_in_d   = d_in_q;
      if (clr) begin
         wptr_d   = '0;
         rptr_d   = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
         addr_w_d = '0;
         addr_r_d = '0;
         d_in_d   = '0;
      end else begin
         if (push_acc) begin
            wptr_d   = wptr_q + DEPTH_LOG2'(1);
            addr_w_d = AW'(wptr_q) << ADDR_SHIFT;
            d_in_d   = push_data;
         end
         if (pop_acc) begin
            rptr_d   = rptr_q + DEPTH_LOG2'(1);
            addr_r_d = AW'(rptr_q) << ADDR_SHIFT;
         end
         count_d = count_q + (DEPTH_LOG2 + 1)'(push_acc) - (DEPTH_LOG2 + 1)'(pop_acc);
         ovf_d   = ovf_q | (push & full_w);
         unf_d   = unf_q | (pop & empty_w);
         csb_d   = ~(push_acc | pop_acc);
         web_d   = ~push_acc;
         reb_d   = ~pop_acc;
      end
   end

   // Valid-token shift register: stage 0 is loaded by an accepted pop, the
   // last stage lines up with read data on sram_d_out. clr drops all tokens.
   generate
      for (genvar gi = 0; gi < LAT; gi++) begin : g_vld
         if (gi == 0) begin : g_head
            assign vld_d[gi] = pop_acc & ~clr;
         end else begin : g_tail
            assign vld_d[gi] = vld_q[gi-1] & ~clr;
         end
      end
   endgenerate

   // State registers, all SRAM-side outputs included.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         csb_q    <= 1'b1;
         web_q    <= 1'b1;
         reb_q    <= 1'b1;
         addr_w_q <= '0;
         addr_r_q <= '0;
         d_in_q   <= '0;
         vld_q    <= '0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         csb_q    <= csb_d;
         web_q    <= web_d;
         reb_q    <= reb_d;
         addr_w_q <= addr_w_d;
         addr_r_q <= addr_r_d;
         d_in_q   <= d_in_d;
         vld_q    <= vld_d;
      end
   end

`ifdef SRAM_FIFO_ALMOST_EN
   logic af_q;
   logic ae_q;

   // Threshold flags are computed from next-state count so they change in
   // the same cycle as count itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         af_q <= 1'b0;
         ae_q <= 1'b1;
      end else begin
         af_q <= (32'(count_d) >= AF_THRESH);
         ae_q <= (32'(count_d) <= AE_THRESH);
      end
   end

   assign almost_full  = af_q;
   assign almost_empty = ae_q;
`endif

   assign full         = full_w;
   assign empty        = empty_w;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;
   assign pop_valid    = vld_q[LAT-1];
   assign pop_data     = pop_valid ? sram_d_out : '0;
   assign sram_csb     = csb_q;
   assign sram_web     = web_q;
   assign sram_reb     = reb_q;
   assign sram_addr_w  = addr_w_q;
   assign sram_addr_r  = addr_r_q;
   assign sram_conf    = CONF;
   assign sram_out_reg = OUT_REG;
   assign sram_d_in    = d_in_q;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed bench for sram_fifo_ctrl with a behavioural
// model of the SRAM macro (1-cycle read, plus an output stage for the
// OUT_REG=1 instance) and a queue of expected read data.
module tb_sram_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic        push = 1'b0;
   logic [31:0] push_data = '0;
   logic        pop = 1'b0;
   logic [31:0] pop_data;
   logic        pop_valid, full, empty, overflow, underflow;
   logic [9:0]  count;
   logic        sram_csb, sram_web, sram_reb, sram_out_reg;
   logic [13:0] sram_addr_w, sram_addr_r;
   logic [2:0]  sram_conf;
   logic [31:0] sram_d_in, sram_d_out;

   // second instance with the macro output register enabled
   logic        b_push = 1'b0;
   logic [31:0] b_push_data = '0;
   logic        b_pop = 1'b0;
   logic [31:0] b_pop_data;
   logic        b_pop_valid, b_full, b_empty, b_overflow, b_underflow;
   logic [9:0]  b_count;
   logic        b_csb, b_web, b_reb, b_out_reg;
   logic [13:0] b_addr_w, b_addr_r;
   logic [2:0]  b_conf;
   logic [31:0] b_d_in, b_d_out;

`ifdef SRAM_FIFO_ALMOST_EN
   logic a_af, a_ae, b_af, b_ae;
`endif

   int          n_checks = 0;
   int          n_fails  = 0;

   // expected-state model
   int          m_count = 0;
   logic [8:0]  m_wptr  = '0;
   logic [8:0]  m_rptr  = '0;
   logic        m_ovf   = 1'b0;
   logic        m_unf   = 1'b0;
   logic [31:0] expq[$];

   always #5 clk = ~clk;

   sram_fifo_ctrl u_dut (
      .clk(clk), .rst(rst), .clr(clr),
      .push(push), .push_data(push_data), .pop(pop),
      .pop_data(pop_data), .pop_valid(pop_valid),
      .full(full), .empty(empty), .count(count),
      .overflow(overflow), .underflow(underflow),
      .sram_csb(sram_csb), .sram_web(sram_web), .sram_reb(sram_reb),
      .sram_addr_w(sram_addr_w), .sram_addr_r(sram_addr_r),
      .sram_conf(sram_conf), .sram_out_reg(sram_out_reg),
      .sram_d_in(sram_d_in), .sram_d_out(sram_d_out)
`ifdef SRAM_FIFO_ALMOST_EN
      , .almost_full(a_af), .almost_empty(a_ae)
`endif
   );

   sram_fifo_ctrl #(.OUT_REG(1'b1)) u_dut_oreg (
      .clk(clk), .rst(rst), .clr(1'b0),
      .push(b_push), .push_data(b_push_data), .pop(b_pop),
      .pop_data(b_pop_data), .pop_valid(b_pop_valid),
      .full(b_full), .empty(b_empty), .count(b_count),
      .overflow(b_overflow), .underflow(b_underflow),
      .sram_csb(b_csb), .sram_web(b_web), .sram_reb(b_reb),
      .sram_addr_w(b_addr_w), .sram_addr_r(b_addr_r),
      .sram_conf(b_conf), .sram_out_reg(b_out_reg),
      .sram_d_in(b_d_in), .sram_d_out(b_d_out)
`ifdef SRAM_FIFO_ALMOST_EN
      , .almost_full(b_af), .almost_empty(b_ae)
`endif
   );

   // SRAM macro models
   logic [31:0] mem_a [0:511];
   logic [31:0] mem_b [0:511];
   logic [31:0] rd_a_q, rd_b_q, rd_b2_q;

   always @(posedge clk) begin
      if (!sram_csb && !sram_web) mem_a[sram_addr_w[13:5]] <= sram_d_in;
      if (!sram_csb && !sram_reb) rd_a_q <= mem_a[sram_addr_r[13:5]];
      if (!b_csb && !b_web) mem_b[b_addr_w[13:5]] <= b_d_in;
      if (!b_csb && !b_reb) rd_b_q <= mem_b[b_addr_r[13:5]];
      rd_b2_q <= rd_b_q;
   end
   assign sram_d_out = rd_a_q;
   assign b_d_out    = rd_b2_q;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // read-stream monitor: every pop_valid must deliver the oldest expected word
   always @(negedge clk) begin
      if (!rst && pop_valid) begin
         if (expq.size() == 0) begin
            check_eq("pop_valid_unexpected", {31'b0, pop_valid}, 32'd0);
         end else begin
            $display("pop  data=%08h", pop_data);
            check_eq("pop_data_order", pop_data, expq.pop_front());
         end
      end
   end

   // one clock of stimulus on the main instance, then compare against the model
   task automatic cyc(input logic pu, input logic [31:0] d, input logic po, input logic cl);
      logic       pa, qa;
      logic [8:0] wp, rp;
      push = pu; push_data = d; pop = po; clr = cl;
      pa = pu && !cl && (m_count < 512);
      qa = po && !cl && (m_count > 0);
      wp = m_wptr;
      rp = m_rptr;
      @(posedge clk); #1;
      if (cl) begin
         m_count = 0; m_wptr = '0; m_rptr = '0; m_ovf = 1'b0; m_unf = 1'b0;
         expq.delete();
      end else begin
         if (pu && m_count == 512) m_ovf = 1'b1;
         if (po && m_count == 0)   m_unf = 1'b1;
         if (pa) begin
            expq.push_back(d);
            m_wptr = m_wptr + 9'd1;
         end
         if (qa) m_rptr = m_rptr + 9'd1;
         m_count = m_count + int'(pa) - int'(qa);
      end
      check_eq("csb", {31'b0, sram_csb}, {31'b0, !(pa || qa)});
      check_eq("web", {31'b0, sram_web}, {31'b0, !pa});
      check_eq("reb", {31'b0, sram_reb}, {31'b0, !qa});
      if (pa) begin
         check_eq("addr_w", {18'b0, sram_addr_w}, {18'b0, wp, 5'b0});
         check_eq("d_in", sram_d_in, d);
      end
      if (qa) check_eq("addr_r", {18'b0, sram_addr_r}, {18'b0, rp, 5'b0});
      if (cl) begin
         check_eq("clr_addr_w", {18'b0, sram_addr_w}, 32'd0);
         check_eq("clr_addr_r", {18'b0, sram_addr_r}, 32'd0);
         check_eq("clr_d_in", sram_d_in, 32'd0);
      end
      check_eq("count", {22'b0, count}, m_count);
      check_eq("full", {31'b0, full}, {31'b0, m_count == 512});
      check_eq("empty", {31'b0, empty}, {31'b0, m_count == 0});
      check_eq("overflow", {31'b0, overflow}, {31'b0, m_ovf});
      check_eq("underflow", {31'b0, underflow}, {31'b0, m_unf});
      push = 1'b0; pop = 1'b0; clr = 1'b0;
   endtask

   initial begin
      // reset state
      #12;
      check_eq("rst_count", {22'b0, count}, 32'd0);
      check_eq("rst_empty", {31'b0, empty}, 32'd1);
      check_eq("rst_full", {31'b0, full}, 32'd0);
      check_eq("rst_csb", {31'b0, sram_csb}, 32'd1);
      check_eq("rst_web", {31'b0, sram_web}, 32'd1);
      check_eq("rst_reb", {31'b0, sram_reb}, 32'd1);
      check_eq("rst_addr_w", {18'b0, sram_addr_w}, 32'd0);
      check_eq("rst_addr_r", {18'b0, sram_addr_r}, 32'd0);
      check_eq("rst_d_in", sram_d_in, 32'd0);
      check_eq("rst_pop_valid", {31'b0, pop_valid}, 32'd0);
      check_eq("rst_flags", {30'b0, overflow, underflow}, 32'd0);
      check_eq("conf", {29'b0, sram_conf}, 32'd0);
      check_eq("out_reg_a", {31'b0, sram_out_reg}, 32'd0);
      check_eq("out_reg_b", {31'b0, b_out_reg}, 32'd1);
      #10 rst = 1'b0;
      @(posedge clk); #1;

      // push four words: write addresses step by 0x20
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 32'hA0 + i, 1'b0, 1'b0);
         check_eq("t1_web", {31'b0, sram_web}, 32'd0);
         check_eq("t1_addr_w", {18'b0, sram_addr_w}, i * 32);
      end
      check_eq("t1_count", {22'b0, count}, 32'd4);
      check_eq("t1_empty", {31'b0, empty}, 32'd0);

      // pop four back-to-back: pop_valid two cycles after each accept
      for (int k = 1; k <= 6; k++) begin
         cyc(1'b0, 32'd0, (k <= 4), 1'b0);
         check_eq("t2_pop_valid", {31'b0, pop_valid}, {31'b0, (k >= 2 && k <= 5)});
         if (k >= 2 && k <= 5) check_eq("t2_pop_data", pop_data, 32'hA0 + k - 2);
         if (k == 4) check_eq("t2_empty", {31'b0, empty}, 32'd1);
      end

      // pop on empty with simultaneous push
      cyc(1'b1, 32'hB5, 1'b1, 1'b0);
      check_eq("t3_underflow", {31'b0, underflow}, 32'd1);
      check_eq("t3_count", {22'b0, count}, 32'd1);
      for (int k = 0; k < 2; k++) begin
         cyc(1'b0, 32'd0, 1'b0, 1'b0);
         check_eq("t3_no_valid", {31'b0, pop_valid}, 32'd0);
      end
      cyc(1'b0, 32'd0, 1'b1, 1'b0);
      cyc(1'b0, 32'd0, 1'b0, 1'b0);
      check_eq("t3_valid", {31'b0, pop_valid}, 32'd1);
      check_eq("t3_data", pop_data, 32'hB5);

      // flush clears the sticky underflow and the pointers
      cyc(1'b0, 32'd0, 1'b0, 1'b1);
      check_eq("t4_underflow_clr", {31'b0, underflow}, 32'd0);

      // fill to 512, then push while full
      for (int i = 0; i < 512; i++) cyc(1'b1, 32'h1000 + i, 1'b0, 1'b0);
      check_eq("t5_full", {31'b0, full}, 32'd1);
      check_eq("t5_count", {22'b0, count}, 32'd512);
      check_eq("t5_last_addr_w", {18'b0, sram_addr_w}, 32'h3FE0);
      cyc(1'b1, 32'hDEAD, 1'b0, 1'b0);
      check_eq("t5_overflow", {31'b0, overflow}, 32'd1);
      check_eq("t5_no_web", {31'b0, sram_web}, 32'd1);
      check_eq("t5_count_sat", {22'b0, count}, 32'd512);
      cyc(1'b1, 32'hBEEF, 1'b1, 1'b0);
      check_eq("t5_full_pushpop_count", {22'b0, count}, 32'd511);
      for (int i = 0; i < 255; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
      check_eq("t5_count_mid", {22'b0, count}, 32'd256);

      // interleaved traffic around half full; write pointer wraps to 0
      for (int i = 0; i < 600; i++) begin
         case (i % 4)
            0:       cyc(1'b1, 32'h5000_0000 + i, 1'b1, 1'b0);
            1:       cyc(1'b1, 32'h5000_0000 + i, 1'b0, 1'b0);
            2:       cyc(1'b0, 32'd0, 1'b1, 1'b0);
            default: cyc(1'b0, 32'd0, 1'b0, 1'b0);
         endcase
         if (i == 0) check_eq("t6_wrap_addr_w", {18'b0, sram_addr_w}, 32'h0000);
      end
      check_eq("t6_count", {22'b0, count}, 32'd256);
      for (int i = 0; i < 256; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 1'b0, 1'b0);
      check_eq("t6_drained", expq.size(), 32'd0);

      // flush with two reads in flight
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'hC0 + i, 1'b0, 1'b0);
      cyc(1'b0, 32'd0, 1'b1, 1'b0);
      cyc(1'b0, 32'd0, 1'b1, 1'b0);
      cyc(1'b0, 32'd0, 1'b0, 1'b1);
      check_eq("t7_overflow_clr", {31'b0, overflow}, 32'd0);
      check_eq("t7_count", {22'b0, count}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         check_eq("t7_no_valid", {31'b0, pop_valid}, 32'd0);
         cyc(1'b0, 32'd0, 1'b0, 1'b0);
      end

      // OUT_REG=1 instance: pop_valid three cycles after accept
      b_push = 1'b1; b_push_data = 32'hC3;
      cyc(1'b0, 32'd0, 1'b0, 1'b0);
      b_push = 1'b0;
      check_eq("t8_web", {31'b0, b_web}, 32'd0);
      b_pop = 1'b1;
      cyc(1'b0, 32'd0, 1'b0, 1'b0);
      b_pop = 1'b0;
      check_eq("t8_reb", {31'b0, b_reb}, 32'd0);
      for (int k = 2; k <= 4; k++) begin
         if (k > 2) cyc(1'b0, 32'd0, 1'b0, 1'b0);
         check_eq("t8_pop_valid", {31'b0, b_pop_valid}, {31'b0, k == 4});
         if (k == 4) check_eq("t8_pop_data", b_pop_data, 32'hC3);
      end
      cyc(1'b0, 32'd0, 1'b0, 1'b0);
      check_eq("t8_valid_pulse", {31'b0, b_pop_valid}, 32'd0);
      check_eq("t8_empty", {31'b0, b_empty}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
Sequencer that turns one unit_SRAM_dp macro into a synchronous 32-bit FIFO for the fabric. It owns the write and read pointers, occupancy and status flags. It drives csb/web/reb/addr_w/addr_r/conf/out_reg/d_fabric_in of the SRAM unit and re-times d_fabric_out into a pop_valid-qualified stream. It sits between fabric producer/consumer logic and the SRAM unit; the two SRAM ports are used as a dedicated write port and a dedicated read port.

Parameters:
DEPTH_LOG2, 9, log2 of FIFO depth in 32-bit words (max 9 = 512 words of one macro)
ADDR_SHIFT, 5, left shift applied to word pointer to form 14-bit SRAM address
CONF, 3'b000, constant driven on sram_conf (32-bit word mode)
OUT_REG, 0, constant driven on sram_out_reg; adds 1 cycle read latency when 1
RD_LAT, 2, cycles from read issue to valid sram_d_out with OUT_REG=0
AF_THRESH, 480, almost-full threshold (optional feature only)
AE_THRESH, 32, almost-empty threshold (optional feature only)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous flush
push  input  1  write request
push_data  input  32  write data
pop  input  1  read request
pop_data  output  32  read data, valid when pop_valid
pop_valid  output  1  one-cycle pulse per accepted pop, L = RD_LAT+OUT_REG cycles after accept
full  output  1  count == 2^DEPTH_LOG2
empty  output  1  count == 0
count  output  DEPTH_LOG2+1  occupancy
overflow  output  1  sticky: push while full
underflow  output  1  sticky: pop while empty
sram_csb  output  1  to SRAM unit csb, active low
sram_web  output  1  to SRAM unit web, active low
sram_reb  output  1  to SRAM unit reb, active low
sram_addr_w  output  14  write address
sram_addr_r  output  14  read address
sram_conf  output  3  = CONF
sram_out_reg  output  1  = OUT_REG
sram_d_in  output  32  to d_fabric_in
sram_d_out  input  32  from d_fabric_out

Behaviour:
- Reset (async) and clr (sync, priority over push/pop): wptr=rptr=0, count=0, overflow=underflow=0, valid pipeline cleared (in-flight reads dropped, no pop_valid), sram_csb=sram_web=sram_reb=1, addresses 0, sram_d_in=0.
- All SRAM-side outputs registered. Idle cycle: csb=web=reb=1.
- Push accepted iff push & !full. Accept at cycle t: at t+1 sram_csb=0, sram_web=0, sram_addr_w=wptr<<ADDR_SHIFT (truncated to 14b), sram_d_in=push_data; wptr increments.
- Pop accepted iff pop & !empty. Accept at t: at t+1 sram_csb=0, sram_reb=0, sram_addr_r=rptr<<ADDR_SHIFT; rptr increments; valid token enters L-stage shift register; pop_valid at t+L, pop_data = sram_d_out combinationally qualified by that stage.
- empty/full/count reflect accepted ops only; push and pop on the same cycle with 0<count<max: count unchanged, both issued (csb=0, web=0, reb=0).
- Empty with push&pop: push accepted, pop rejected, underflow set. Full with push&pop: pop accepted, push rejected, overflow set.
- Read never targets an unwritten word: write hits the macro one cycle before any dependent read.
- Pointers DEPTH_LOG2 bits, wrap 2^DEPTH_LOG2-1 -> 0; count saturates naturally at 2^DEPTH_LOG2.
- Sticky flags cleared only by rst or clr.

Optional Feature:
SRAM_FIFO_ALMOST_EN: when defined, adds outputs almost_full (count >= AF_THRESH) and almost_empty (count <= AE_THRESH), registered with count. When undefined, ports and logic are absent and AF_THRESH/AE_THRESH are unused.

Test Plan:
- Reset, push 4 words 0xA0..0xA3 -> sram_web low 4 cycles, sram_addr_w 0x000,0x020,0x040,0x060; count=4; empty=0.
- Pop 4 after fill -> pop_valid at accept+2 each, pop_data 0xA0..0xA3 in order; empty=1 after last accept.
- Fill 512 words -> full=1, count=512; extra push -> overflow=1, count stays 512, no sram_web pulse.
- Pop on empty with simultaneous push -> underflow=1, count=1, no pop_valid; subsequent pop returns pushed word.
- 600 interleaved push/pop at count≈256 crossing pointer wrap -> data order preserved, addr_w wraps 0x3FE0->0x0000.
- clr with 2 reads in flight -> no pop_valid thereafter, count=0, flags cleared; OUT_REG=1 build -> pop_valid at accept+3.
